// File: rtl/imm_extend_pipe_if.sv
// Handshake bundle for imm_extend_pipe: input beat channel plus result channel.
// out_zero exists only when IMM_EXT_ZERO_FLAG_EN is defined.
interface imm_extend_pipe_if #(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 32
);
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_imm;
  logic [1:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
`ifdef IMM_EXT_ZERO_FLAG_EN
  logic             out_zero;
`endif

  modport master (
    output in_valid, in_imm, in_mode, out_ready,
`ifdef IMM_EXT_ZERO_FLAG_EN
    input  out_zero,
`endif
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_imm, in_mode, out_ready,
`ifdef IMM_EXT_ZERO_FLAG_EN
    output out_zero,
`endif
    output in_ready, out_valid, out_data
  );
endinterface

// File: rtl/imm_extend_pipe.sv
// Pipelined immediate extender (SEXT/ZEXT/UPPER/BRANCH) with a 2-entry skid buffer.
// Optional registered zero flag on the result when IMM_EXT_ZERO_FLAG_EN is defined.
module imm_extend_pipe #(
  parameter int unsigned IN_W  = 16,
  parameter int unsigned OUT_W = 32
) (
  input logic               clk,
  input logic               rst,
  imm_extend_pipe_if.slave  io_bus
);

  typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

  state_e           r_state;
  logic             r_out_valid;
  logic             r_skid_v;
  logic [OUT_W-1:0] r_main_d;
  logic [OUT_W-1:0] r_skid_d;

  logic [OUT_W-1:0] w_sext;
  logic [OUT_W-1:0] w_zext;
  logic [OUT_W-1:0] w_ext;
  logic             w_acc;
  logic             w_drain;
  logic             w_main_ld_new;
  logic             w_main_ld_skid;
  logic             w_skid_ld;

  assign w_sext = {{(OUT_W-IN_W){io_bus.in_imm[IN_W-1]}}, io_bus.in_imm};
  assign w_zext = {{(OUT_W-IN_W){1'b0}}, io_bus.in_imm};

  always_comb begin
    w_ext = '0;
    unique case (io_bus.in_mode)
      2'b00: w_ext = w_sext;
      2'b01: w_ext = w_zext;
      2'b10: w_ext = w_zext << IN_W;  // upper bits beyond OUT_W fall off
      2'b11: w_ext = w_sext << 2;
    endcase
  end

  // in_ready is the registered inverse of the skid flag, never a path from out_ready.
  assign w_acc          = io_bus.in_valid && !r_skid_v;
  assign w_drain        = r_out_valid && io_bus.out_ready;
  assign w_main_ld_new  = w_acc && (!r_out_valid || w_drain);
  assign w_skid_ld      = w_acc && r_out_valid && !w_drain;
  assign w_main_ld_skid = r_skid_v && w_drain;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= StEmpty;
      r_out_valid <= 1'b0;
      r_skid_v    <= 1'b0;
    end else begin
      unique case (r_state)
        StEmpty: begin
          if (w_acc) begin
            r_state     <= StOne;
            r_out_valid <= 1'b1;
          end
        end
        StOne: begin
          if (w_skid_ld) begin
            r_state  <= StFull;
            r_skid_v <= 1'b1;
          end else if (w_drain && !w_acc) begin
            r_state     <= StEmpty;
            r_out_valid <= 1'b0;
          end
        end
        StFull: begin
          if (w_drain) begin
            r_state  <= StOne;
            r_skid_v <= 1'b0;
          end
        end
        default: begin
          r_state     <= StEmpty;
          r_out_valid <= 1'b0;
          r_skid_v    <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_main_d <= '0;
      r_skid_d <= '0;
    end else begin
      if (w_main_ld_skid) begin
        r_main_d <= r_skid_d;
      end else if (w_main_ld_new) begin
        r_main_d <= w_ext;
      end
      if (w_skid_ld) begin
        r_skid_d <= w_ext;
      end
    end
  end

`ifdef IMM_EXT_ZERO_FLAG_EN
  logic r_main_z;
  logic r_skid_z;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_main_z <= 1'b0;
      r_skid_z <= 1'b0;
    end else begin
      if (w_main_ld_skid) begin
        r_main_z <= r_skid_z;
      end else if (w_main_ld_new) begin
        r_main_z <= (w_ext == '0);
      end
      if (w_skid_ld) begin
        r_skid_z <= (w_ext == '0);
      end
    end
  end

  assign io_bus.out_zero = r_main_z;
`endif

  assign io_bus.in_ready  = !r_skid_v;
  assign io_bus.out_valid = r_out_valid;
  assign io_bus.out_data  = r_main_d;

  // A filled skid with an empty main register would reorder beats.
  a_no_skid_without_main: assert property (@(posedge clk) disable iff (rst)
    !(r_skid_v && !r_out_valid));

endmodule

// File: tb/tb_imm_extend_pipe.sv
// Directed bench for imm_extend_pipe: mode table, backpressure, streaming, reset, corner widths.
// Zero-flag checks are compiled in when IMM_EXT_ZERO_FLAG_EN is defined.
module tb_imm_extend_pipe;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  imm_extend_pipe_if #(.IN_W(16), .OUT_W(32)) bus_a ();
  imm_extend_pipe_if #(.IN_W(12), .OUT_W(16)) bus_b ();

  imm_extend_pipe #(.IN_W(16), .OUT_W(32)) u_dut_a (.clk(clk), .rst(rst), .io_bus(bus_a));
  imm_extend_pipe #(.IN_W(12), .OUT_W(16)) u_dut_b (.clk(clk), .rst(rst), .io_bus(bus_b));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Independent reference for the scoreboard, written with signed arithmetic.
  function automatic logic [31:0] model(input logic [15:0] imm, input logic [1:0] m);
    logic signed [31:0] s;
    s = $signed(imm);
    case (m)
      2'd0:    return s;
      2'd1:    return {16'h0000, imm};
      2'd2:    return {16'h0000, imm} * 32'd65536;
      default: return s * 4;
    endcase
  endfunction

  // Inputs change #1 after posedge, so at negedge both sides are stable.
  logic [31:0] sb_q[$];
  always @(negedge clk) begin
    if (rst) begin
      sb_q.delete();
    end else begin
      if (bus_a.in_valid && bus_a.in_ready) sb_q.push_back(model(bus_a.in_imm, bus_a.in_mode));
      if (bus_a.out_valid && bus_a.out_ready) begin
        if (sb_q.size() == 0) begin
          check("sb_unexpected_beat", bus_a.out_data, 32'hxxxxxxxx);
        end else begin
          check("sb_order", bus_a.out_data, sb_q.pop_front());
        end
      end
    end
  end

  typedef struct {
    logic [1:0]  mode;
    logic [15:0] imm;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[10];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    vecs[0] = '{2'd0, 16'h8001, 32'hFFFF8001};
    vecs[1] = '{2'd1, 16'h8001, 32'h00008001};
    vecs[2] = '{2'd2, 16'h8001, 32'h80010000};
    vecs[3] = '{2'd3, 16'h8001, 32'hFFFE0004};
    vecs[4] = '{2'd0, 16'h7FFF, 32'h00007FFF};
    vecs[5] = '{2'd1, 16'hFFFF, 32'h0000FFFF};
    vecs[6] = '{2'd2, 16'h0001, 32'h00010000};
    vecs[7] = '{2'd3, 16'h7FFF, 32'h0001FFFC};
    vecs[8] = '{2'd3, 16'hFFFF, 32'hFFFFFFFC};
    vecs[9] = '{2'd0, 16'h0000, 32'h00000000};

    bus_a.in_valid = 1'b0; bus_a.in_imm = '0; bus_a.in_mode = 2'd0; bus_a.out_ready = 1'b1;
    bus_b.in_valid = 1'b0; bus_b.in_imm = '0; bus_b.in_mode = 2'd0; bus_b.out_ready = 1'b1;

    // Reset state
    #2;
    check("rst_out_valid", 32'(bus_a.out_valid), 32'd0);
    check("rst_in_ready",  32'(bus_a.in_ready),  32'd1);
    check("rst_out_data",  bus_a.out_data,       32'd0);
`ifdef IMM_EXT_ZERO_FLAG_EN
    check("rst_out_zero",  32'(bus_a.out_zero),  32'd0);
`endif
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Mode table, back-to-back with one-cycle latency
    for (int i = 0; i < 10; i++) begin
      bus_a.in_valid = 1'b1;
      bus_a.in_mode  = vecs[i].mode;
      bus_a.in_imm   = vecs[i].imm;
      tick();
      check($sformatf("vec%0d_valid", i), 32'(bus_a.out_valid), 32'd1);
      check($sformatf("vec%0d_data", i),  bus_a.out_data,       vecs[i].exp);
      check($sformatf("vec%0d_ready", i), 32'(bus_a.in_ready),  32'd1);
    end
    bus_a.in_valid = 1'b0;
    tick();
    check("drain_empty", 32'(bus_a.out_valid), 32'd0);

    // Backpressure: 1, 2 fill main+skid, 3 is held by the sender
    bus_a.out_ready = 1'b0;
    bus_a.in_valid  = 1'b1;
    bus_a.in_mode   = 2'd1;
    bus_a.in_imm    = 16'd1;
    tick();
    check("bp_one_ready", 32'(bus_a.in_ready), 32'd1);
    bus_a.in_imm = 16'd2;
    tick();
    check("bp_full_ready", 32'(bus_a.in_ready), 32'd0);
    check("bp_full_data",  bus_a.out_data,      32'd1);
    bus_a.in_imm = 16'd3;
    tick();
    tick();
    check("bp_hold_ready", 32'(bus_a.in_ready),  32'd0);
    check("bp_hold_valid", 32'(bus_a.out_valid), 32'd1);
    check("bp_hold_data",  bus_a.out_data,       32'd1);
    bus_a.out_ready = 1'b1;
    tick();
    check("bp_drain1_data",  bus_a.out_data,      32'd2);
    check("bp_drain1_ready", 32'(bus_a.in_ready), 32'd1);
    tick();
    bus_a.in_valid = 1'b0;
    check("bp_drain2_data", bus_a.out_data, 32'd3);
    tick();
    check("bp_drain3_empty", 32'(bus_a.out_valid), 32'd0);
    check("bp_sb_empty", 32'(sb_q.size()), 32'd0);

    // Streaming: one result per cycle, never stalls
    for (int i = 0; i < 100; i++) begin
      bus_a.in_valid = 1'b1;
      bus_a.in_imm   = 16'($urandom);
      bus_a.in_mode  = 2'($urandom_range(0, 3));
      tick();
      check("stream_ready", 32'(bus_a.in_ready),  32'd1);
      check("stream_valid", 32'(bus_a.out_valid), 32'd1);
    end
    bus_a.in_valid = 1'b0;
    tick();
    check("stream_sb_empty", 32'(sb_q.size()), 32'd0);

    // Reset mid-transfer while FULL
    bus_a.out_ready = 1'b0;
    bus_a.in_valid  = 1'b1;
    bus_a.in_mode   = 2'd0;
    bus_a.in_imm    = 16'h1234;
    tick();
    bus_a.in_imm = 16'h5678;
    tick();
    check("rstfull_ready_pre", 32'(bus_a.in_ready), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    check("rstfull_out_valid", 32'(bus_a.out_valid), 32'd0);
    check("rstfull_in_ready",  32'(bus_a.in_ready),  32'd1);
    check("rstfull_out_data",  bus_a.out_data,       32'd0);
    bus_a.in_valid  = 1'b0;
    bus_a.out_ready = 1'b1;
    tick();
    rst = 1'b0;
    tick();
    tick();
    check("rstfull_no_ghost", 32'(bus_a.out_valid), 32'd0);

`ifdef IMM_EXT_ZERO_FLAG_EN
    // Zero flag, plain and across a FULL stall
    bus_a.in_valid = 1'b1;
    bus_a.in_mode  = 2'd1;
    bus_a.in_imm   = 16'd0;
    tick();
    check("zf_zero", 32'(bus_a.out_zero), 32'd1);
    bus_a.in_imm = 16'd1;
    tick();
    check("zf_nonzero", 32'(bus_a.out_zero), 32'd0);
    bus_a.in_valid = 1'b0;
    tick();
    bus_a.out_ready = 1'b0;
    bus_a.in_valid  = 1'b1;
    bus_a.in_imm    = 16'd0;
    tick();
    bus_a.in_imm = 16'd1;
    tick();
    bus_a.in_valid = 1'b0;
    tick();
    check("zf_stall_ready", 32'(bus_a.in_ready), 32'd0);
    check("zf_stall_zero",  32'(bus_a.out_zero), 32'd1);
    bus_a.out_ready = 1'b1;
    tick();
    check("zf_after_zero", 32'(bus_a.out_zero), 32'd0);
    check("zf_after_data", bus_a.out_data,      32'd1);
    tick();
`endif

    // Narrow instance: IN_W=12, OUT_W=16
    bus_b.in_valid = 1'b1;
    bus_b.in_mode  = 2'd2;
    bus_b.in_imm   = 12'hABC;
    tick();
    check("narrow_upper", 32'(bus_b.out_data), 32'h0000C000);
    bus_b.in_mode = 2'd3;
    bus_b.in_imm  = 12'h800;
    tick();
    check("narrow_branch", 32'(bus_b.out_data), 32'h0000E000);
    bus_b.in_mode = 2'd0;
    tick();
    check("narrow_sext", 32'(bus_b.out_data), 32'h0000F800);
    bus_b.in_valid = 1'b0;
    tick();
    check("narrow_empty", 32'(bus_b.out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
